chacha_host_driver: RTL and testbench
=====================================

Name: chacha_host_driver

Overview:
- Host-side counterpart of the ChaCha20 accelerator top.
- Holds key, nonce, counter and one 512-bit plaintext block, loaded over a simple register-write port. Answers the accelerator's chunk requests and transmits the plaintext words. Captures the 16 ciphertext words into a readable buffer.
- Optionally auto-increments the block counter after each completed block, for multi-block messages.

Parameters:
- NWORDS, 16, words per block in each direction
- KEY_WORDS, 8, 32-bit key chunks (indices 0..7)
- NONCE_WORDS, 3, 32-bit nonce chunks (indices 0..2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  register write strobe
- cfg_waddr  in  5  write address: 0-7 key, 8-10 nonce, 11 counter, 12 ctrl, 13 cmd, 16-31 plaintext word 0-15; 14-15 ignored
- cfg_wdata  in  32  write data
- cfg_raddr  in  5  read address: 0-15 ciphertext word, 16 status, 17 counter; other addresses read 0
- cfg_rdata  out  32  read data, registered, 1-cycle latency
- blk_done  out  1  one-cycle pulse when a block completes
- start  out  1  one-cycle start pulse to the accelerator
- busy  in  1  accelerator busy
- done  in  1  accelerator done pulse
- use_streamed_key/use_streamed_nonce/use_streamed_counter  out  1 each  ctrl bits 0/1/2
- chunk_request  in  1  accelerator requests a chunk
- request_type  in  2  0 key, 1 nonce, 2 counter
- chunk_index  in  5  requested chunk index
- chunk_valid  out  1  response valid
- chunk_type  out  2  echoes the type being answered
- chunk  out  32  response data
- in_state_word  out  32  plaintext word
- in_state_valid  out  1  plaintext valid
- in_state_ready  in  1  accelerator ready for plaintext
- out_state_word  in  32  ciphertext word
- out_state_valid  in  1  ciphertext valid
- out_state_ready  out  1  driver ready for ciphertext

Behaviour:
- Reset: all registers, buffers, pointers and flags go to 0.
  - FSM goes to IDLE.
  - All outputs are 0: start, blk_done, chunk_valid, chunk_type, chunk, in_state_valid, in_state_word, out_state_ready, cfg_rdata, use_streamed_*.
  - Reset mid-block abandons the block; no blk_done is issued.
- ctrl register (addr 12): bit0-2 drive use_streamed_key/nonce/counter; bit3 auto_inc.
- Writes to key/nonce/counter/ctrl/plaintext are ignored while the FSM is not IDLE.
- Command (addr 13): a write with bit0=1 in IDLE moves the FSM to START.
  - The same command in any other state is ignored and sets sticky cmd_err.
  - Status bit2 (cmd_err) is cleared by a write to addr 13 with bit31=1; bit31 clears all three sticky error bits.
- FSM states:
  - IDLE
  - START: waits for busy==0, then drives start=1 for exactly one cycle and goes to RUN; tx_ptr and rx_ptr clear to 0 on entry.
  - RUN: chunk responder, plaintext transmitter and ciphertext receiver all operate concurrently; done==1 moves the FSM to FINISH.
  - FINISH: pulses blk_done for one cycle, returns to IDLE. If auto_inc=1, counter <= counter+1 (mod 2^32); a wrap from 0xFFFFFFFF to 0 sets sticky ctr_wrap (status bit3).
- Chunk responder (RUN only):
  - If chunk_request=1 is sampled and chunk_valid is currently 0, then next cycle chunk_valid=1 for exactly one cycle.
  - In that cycle, chunk_type=request_type and chunk = key[idx], nonce[idx] or counter, per the sampled request.
  - A request sampled while chunk_valid=1 is dropped; the accelerator re-requests.
  - Out-of-range index (key>7, nonce>2, counter>0) or type 3: still respond, with chunk=0, and set sticky idx_err (status bit1).
- Plaintext transmit:
  - in_state_valid = RUN && tx_ptr<16 && in_state_ready (combinational gate on ready).
  - in_state_word = pt[tx_ptr].
  - tx_ptr increments on every cycle in_state_valid=1.
- Ciphertext receive:
  - out_state_ready = RUN && rx_ptr<16.
  - On out_state_valid && out_state_ready: ct[rx_ptr] <= out_state_word and rx_ptr increments.
  - Capture is also enabled in the done cycle.
- done handling: if done arrives with rx_ptr<16 or tx_ptr<16, set sticky blk_err (status bit0). Captured words are kept; words never received read as 0. ct clears to 0 at START.
- Status register (addr 16):
  - bit0 blk_err, bit1 idx_err, bit2 cmd_err, bit3 ctr_wrap
  - bit4 (FSM!=IDLE), bits[12:8] tx_ptr, bits[20:16] rx_ptr
- Reads are allowed in any state.

Test Plan:
- Load key words 0x00010203..0x1C1D1E1F, nonce, counter=1, ctrl=0x7, cmd=1; accelerator model requests key idx 0..7 → each chunk_valid pulse is 1 cycle after its request, with the matching key word and chunk_type=0.
- Plaintext words 0x100+i → model sees 16 valid beats, only while in_state_ready=1, in order; in_state_ready low for 3 cycles mid-block → tx_ptr holds, no beat is lost or duplicated.
- Model returns 0xC000+i with out_state_valid → ct reads 0xC000..0xC00F; blk_done pulses once; status=0.
- auto_inc=1, counter=0xFFFFFFFF, one block → counter reads 0, status bit3=1; a second block requests counter and receives 0.
- Request key idx 9 → chunk=0, idx_err=1; done after only 10 ct beats → blk_err=1, rx_ptr=10.
- cmd written during RUN → cmd_err=1, no extra start; rst asserted in RUN → next cycle all outputs 0, FSM IDLE, no blk_done.

Source files
------------

// File: rtl/chacha_host_driver.sv
// Host-side driver for the ChaCha20 accelerator: register-loaded key/nonce/counter/plaintext,
// chunk-request responder, plaintext transmitter and ciphertext capture buffer.
module chacha_host_driver #(
   parameter int unsigned NWORDS      = 16,
   parameter int unsigned KEY_WORDS   = 8,
   parameter int unsigned NONCE_WORDS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [4:0]  cfg_waddr,
   input  logic [31:0] cfg_wdata,
   input  logic [4:0]  cfg_raddr,
   output logic [31:0] cfg_rdata,
   output logic        blk_done,
   output logic        start,
   input  logic        busy,
   input  logic        done,
   output logic        use_streamed_key,
   output logic        use_streamed_nonce,
   output logic        use_streamed_counter,
   input  logic        chunk_request,
   input  logic [1:0]  request_type,
   input  logic [4:0]  chunk_index,
   output logic        chunk_valid,
   output logic [1:0]  chunk_type,
   output logic [31:0] chunk,
   output logic [31:0] in_state_word,
   output logic        in_state_valid,
   input  logic        in_state_ready,
   input  logic [31:0] out_state_word,
   input  logic        out_state_valid,
   output logic        out_state_ready
);
   localparam int unsigned PTR_W = $clog2(NWORDS + 1);
   localparam int unsigned WI_W  = $clog2(NWORDS);
   localparam int unsigned KI_W  = $clog2(KEY_WORDS);
   localparam int unsigned NI_W  = $clog2(NONCE_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FINISH} state_t;
   state_t state, state_nxt;

   logic [31:0] key   [KEY_WORDS];
   logic [31:0] nonce [NONCE_WORDS];
   logic [31:0] pt    [NWORDS];
   logic [31:0] ct    [NWORDS];
   logic [31:0] counter;
   logic [3:0]  ctrl;
   logic [PTR_W-1:0] tx_ptr, rx_ptr, tx_ptr_nxt, rx_ptr_nxt;
   logic blk_err, idx_err, cmd_err, ctr_wrap;

   logic        cmd_wr, cmd_go, rx_beat, idx_bad;
   logic [31:0] chunk_nxt, status;

   assign cmd_wr = cfg_we && (cfg_waddr == 5'd13);
   assign cmd_go = cmd_wr && cfg_wdata[0] && (state == S_IDLE);

   assign use_streamed_key     = ctrl[0];
   assign use_streamed_nonce   = ctrl[1];
   assign use_streamed_counter = ctrl[2];

   // Streaming handshakes are qualified by state and pointer, and by ready on the transmit side
   assign in_state_valid  = (state == S_RUN) && (tx_ptr < PTR_W'(NWORDS)) && in_state_ready;
   assign in_state_word   = pt[tx_ptr[WI_W-1:0]];
   assign out_state_ready = (state == S_RUN) && (rx_ptr < PTR_W'(NWORDS));
   assign rx_beat         = out_state_valid && out_state_ready;
   assign tx_ptr_nxt      = tx_ptr + PTR_W'(in_state_valid);
   assign rx_ptr_nxt      = rx_ptr + PTR_W'(rx_beat);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (cmd_go) state_nxt = S_START;
         S_START:  if (!busy) state_nxt = S_RUN;
         S_RUN:    if (done) state_nxt = S_FINISH;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Chunk lookup; out-of-range requests answer 0 and flag idx_bad
   always_comb begin
      chunk_nxt = '0;
      idx_bad   = 1'b0;
      case (request_type)
         2'd0: if (chunk_index < 5'(KEY_WORDS)) chunk_nxt = key[chunk_index[KI_W-1:0]];
               else idx_bad = 1'b1;
         2'd1: if (chunk_index < 5'(NONCE_WORDS)) chunk_nxt = nonce[chunk_index[NI_W-1:0]];
               else idx_bad = 1'b1;
         2'd2: if (chunk_index == 5'd0) chunk_nxt = counter;
               else idx_bad = 1'b1;
         default: idx_bad = 1'b1;
      endcase
   end

   always_comb begin
      status        = '0;
      status[0]     = blk_err;
      status[1]     = idx_err;
      status[2]     = cmd_err;
      status[3]     = ctr_wrap;
      status[4]     = (state != S_IDLE);
      status[12:8]  = 5'(tx_ptr);
      status[20:16] = 5'(rx_ptr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         for (int unsigned i = 0; i < KEY_WORDS; i++)   key[i]   <= '0;
         for (int unsigned i = 0; i < NONCE_WORDS; i++) nonce[i] <= '0;
         for (int unsigned i = 0; i < NWORDS; i++) begin
            pt[i] <= '0;
            ct[i] <= '0;
         end
         counter     <= '0;
         ctrl        <= '0;
         tx_ptr      <= '0;
         rx_ptr      <= '0;
         blk_err     <= 1'b0;
         idx_err     <= 1'b0;
         cmd_err     <= 1'b0;
         ctr_wrap    <= 1'b0;
         start       <= 1'b0;
         blk_done    <= 1'b0;
         chunk_valid <= 1'b0;
         chunk_type  <= '0;
         chunk       <= '0;
         cfg_rdata   <= '0;
      end else begin
         state    <= state_nxt;
         start    <= (state == S_START) && !busy;
         blk_done <= (state == S_FINISH);

         // Configuration is frozen while a block is in flight
         if (cfg_we && state == S_IDLE) begin
            if (cfg_waddr[4])              pt[cfg_waddr[WI_W-1:0]] <= cfg_wdata;
            else if (cfg_waddr < 5'd8)     key[cfg_waddr[KI_W-1:0]] <= cfg_wdata;
            else if (cfg_waddr <= 5'd10)   nonce[cfg_waddr[NI_W-1:0]] <= cfg_wdata;
            else if (cfg_waddr == 5'd11)   counter <= cfg_wdata;
            else if (cfg_waddr == 5'd12)   ctrl <= cfg_wdata[3:0];
         end

         // Clear first so that a same-cycle error event still sets its flag
         if (cmd_wr && cfg_wdata[31]) begin
            blk_err <= 1'b0;
            idx_err <= 1'b0;
            cmd_err <= 1'b0;
         end
         if (cmd_wr && cfg_wdata[0] && state != S_IDLE) cmd_err <= 1'b1;

         if (cmd_go) begin
            tx_ptr <= '0;
            rx_ptr <= '0;
            for (int unsigned i = 0; i < NWORDS; i++) ct[i] <= '0;
         end

         chunk_valid <= 1'b0;
         if (state == S_RUN) begin
            if (chunk_request && !chunk_valid) begin
               chunk_valid <= 1'b1;
               chunk_type  <= request_type;
               chunk       <= chunk_nxt;
               if (idx_bad) idx_err <= 1'b1;
            end
            tx_ptr <= tx_ptr_nxt;
            if (rx_beat) begin
               ct[rx_ptr[WI_W-1:0]] <= out_state_word;
               rx_ptr <= rx_ptr_nxt;
            end
            if (done && (tx_ptr_nxt < PTR_W'(NWORDS) || rx_ptr_nxt < PTR_W'(NWORDS)))
               blk_err <= 1'b1;
         end

         if (state == S_FINISH && ctrl[3]) begin
            counter <= counter + 32'd1;
            if (counter == 32'hFFFF_FFFF) ctr_wrap <= 1'b1;
         end

         if (!cfg_raddr[4])             cfg_rdata <= ct[cfg_raddr[WI_W-1:0]];
         else if (cfg_raddr == 5'd16)   cfg_rdata <= status;
         else if (cfg_raddr == 5'd17)   cfg_rdata <= counter;
         else                           cfg_rdata <= '0;
      end
   end
endmodule

// File: tb/tb_chacha_host_driver.sv
// Directed bench for chacha_host_driver: table-driven chunk/readback vectors plus an
// accelerator-side model for the streaming, error and reset sequences.
module tb_chacha_host_driver;
   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [4:0]  cfg_waddr;
   logic [31:0] cfg_wdata;
   logic [4:0]  cfg_raddr;
   logic [31:0] cfg_rdata;
   logic        blk_done, start, busy, done;
   logic        use_streamed_key, use_streamed_nonce, use_streamed_counter;
   logic        chunk_request;
   logic [1:0]  request_type;
   logic [4:0]  chunk_index;
   logic        chunk_valid;
   logic [1:0]  chunk_type;
   logic [31:0] chunk;
   logic [31:0] in_state_word;
   logic        in_state_valid, in_state_ready;
   logic [31:0] out_state_word;
   logic        out_state_valid, out_state_ready;

   chacha_host_driver dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
      .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata),
      .blk_done(blk_done), .start(start), .busy(busy), .done(done),
      .use_streamed_key(use_streamed_key), .use_streamed_nonce(use_streamed_nonce),
      .use_streamed_counter(use_streamed_counter),
      .chunk_request(chunk_request), .request_type(request_type), .chunk_index(chunk_index),
      .chunk_valid(chunk_valid), .chunk_type(chunk_type), .chunk(chunk),
      .in_state_word(in_state_word), .in_state_valid(in_state_valid),
      .in_state_ready(in_state_ready),
      .out_state_word(out_state_word), .out_state_valid(out_state_valid),
      .out_state_ready(out_state_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  rtype;
      logic [4:0]  idx;
      logic [31:0] exp;
   } chunk_vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] exp;
   } rd_vec_t;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int done_cnt = 0;

   // Pulse counters: registered pulses are seen once per posedge they are high
   always @(posedge clk) begin
      if (start)    start_cnt++;
      if (blk_done) done_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got hang expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_waddr = addr; cfg_wdata = data;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [4:0] addr, output logic [31:0] data);
      @(negedge clk);
      cfg_raddr = addr;
      @(negedge clk);
      data = cfg_rdata;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ctl"}, {22'd0, start, blk_done, chunk_valid, chunk_type, in_state_valid,
             out_state_ready, use_streamed_key, use_streamed_nonce, use_streamed_counter}, 32'd0);
      check({tag, "_chunk"}, chunk, 32'd0);
      check({tag, "_in_word"}, in_state_word, 32'd0);
      check({tag, "_rdata"}, cfg_rdata, 32'd0);
   endtask

   task automatic begin_block(input int busy_cycles);
      int s0;
      bit seen;
      s0 = start_cnt;
      busy = (busy_cycles > 0);
      wr(5'd13, 32'd1);
      for (int i = 0; i < busy_cycles; i++) @(negedge clk);
      check("no_start_while_busy", 32'(start_cnt - s0), 32'd0);
      busy = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (start) seen = 1'b1;
      end
      check("start_pulse_seen", 32'(seen), 32'd1);
   endtask

   task automatic chunk_req(input chunk_vec_t v, input int n);
      @(negedge clk);
      chunk_request = 1'b1; request_type = v.rtype; chunk_index = v.idx;
      @(negedge clk);
      chunk_request = 1'b0;
      check($sformatf("chunk_data_%0d", n), chunk, v.exp);
      check($sformatf("chunk_vt_%0d", n), {29'd0, chunk_valid, chunk_type}, {29'd0, 1'b1, v.rtype});
      @(negedge clk);
      check($sformatf("chunk_one_cycle_%0d", n), 32'(chunk_valid), 32'd0);
   endtask

   task automatic stream(input int n_ct, input int stall_at);
      int tx_seen, ct_sent, cyc;
      tx_seen = 0; ct_sent = 0; cyc = 0;
      while ((tx_seen < 16 || ct_sent < n_ct) && cyc < 100) begin
         @(negedge clk);
         in_state_ready  = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
         out_state_valid = (ct_sent < n_ct);
         out_state_word  = 32'hC000 + 32'(ct_sent);
         #1;
         if (!in_state_ready) begin
            check("stall_no_valid", 32'(in_state_valid), 32'd0);
            check("stall_hold_word", in_state_word, 32'h100 + 32'(tx_seen));
         end else if (in_state_valid) begin
            check($sformatf("pt_beat_%0d", tx_seen), in_state_word, 32'h100 + 32'(tx_seen));
            tx_seen++;
         end
         if (out_state_valid && out_state_ready) ct_sent++;
         cyc++;
      end
      check("stream_budget", 32'(cyc < 100), 32'd1);
      @(negedge clk);
      in_state_ready  = 1'b1;
      out_state_valid = 1'b0;
      #1;
      check("no_extra_pt_beat", 32'(in_state_valid), 32'd0);
      check("rx_ready_after", 32'(out_state_ready), 32'(n_ct < 16));
      in_state_ready = 1'b0;
   endtask

   task automatic finish_block();
      @(negedge clk); done = 1'b1;
      @(negedge clk); done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   chunk_vec_t cv [16];
   rd_vec_t    rv [18];
   logic [31:0] key_words [8];
   logic [31:0] rdat;
   int s0, d0;
   logic [2:0] drop_pat;

   initial begin
      key_words = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                    32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
      for (int i = 0; i < 8; i++) cv[i] = '{2'd0, 5'(i), key_words[i]};
      cv[8]  = '{2'd1, 5'd0, 32'hA0A1A2A3};
      cv[9]  = '{2'd1, 5'd1, 32'hB0B1B2B3};
      cv[10] = '{2'd1, 5'd2, 32'hC0C1C2C3};
      cv[11] = '{2'd2, 5'd0, 32'h00000001};
      cv[12] = '{2'd2, 5'd0, 32'h00000000};
      cv[13] = '{2'd0, 5'd9, 32'h00000000};
      cv[14] = '{2'd3, 5'd0, 32'h00000000};
      cv[15] = '{2'd1, 5'd3, 32'h00000000};
      for (int i = 0; i < 16; i++) rv[i] = '{5'(i), 32'hC000 + 32'(i)};
      rv[16] = '{5'd16, 32'h00101000};
      rv[17] = '{5'd17, 32'h00000001};

      rst = 1'b1; cfg_we = 1'b0; cfg_waddr = '0; cfg_wdata = '0; cfg_raddr = '0;
      busy = 1'b0; done = 1'b0; chunk_request = 1'b0; request_type = '0; chunk_index = '0;
      in_state_ready = 1'b0; out_state_word = '0; out_state_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 8; i++) wr(5'(i), key_words[i]);
      wr(5'd8, 32'hA0A1A2A3);
      wr(5'd9, 32'hB0B1B2B3);
      wr(5'd10, 32'hC0C1C2C3);
      wr(5'd11, 32'd1);
      wr(5'd12, 32'h7);
      for (int i = 0; i < 16; i++) wr(5'(16 + i), 32'h100 + 32'(i));
      check("use_streamed", {29'd0, use_streamed_key, use_streamed_nonce, use_streamed_counter},
            32'h7);

      // Block 1: busy delays start, all chunks answered, stall mid plaintext stream
      s0 = start_cnt; d0 = done_cnt;
      begin_block(3);
      for (int i = 0; i < 12; i++) chunk_req(cv[i], i);
      @(negedge clk);
      chunk_request = 1'b1; request_type = 2'd0; chunk_index = 5'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drop_pat[2-i] = chunk_valid;
      end
      chunk_request = 1'b0;
      check("held_request_pattern", {29'd0, drop_pat}, 32'h5);
      stream(16, 4);
      finish_block();
      check("blk1_start_count", 32'(start_cnt - s0), 32'd1);
      check("blk1_done_count", 32'(done_cnt - d0), 32'd1);
      for (int i = 0; i < 18; i++) begin
         rd(rv[i].addr, rdat);
         check($sformatf("blk1_rd_%0d", rv[i].addr), rdat, rv[i].exp);
      end

      // Block 2: counter wrap with auto increment
      wr(5'd11, 32'hFFFF_FFFF);
      wr(5'd12, 32'hF);
      begin_block(0);
      stream(16, -1);
      finish_block();
      rd(5'd17, rdat); check("wrap_counter", rdat, 32'd0);
      rd(5'd16, rdat); check("wrap_status", rdat, 32'h00101008);

      // Block 3: counter request after wrap, bad indices, short ciphertext, frozen config
      s0 = start_cnt; d0 = done_cnt;
      begin_block(0);
      chunk_req(cv[12], 12);
      wr(5'd11, 32'h55);
      for (int i = 13; i < 16; i++) chunk_req(cv[i], i);
      rd(5'd16, rdat); check("blk3_mid_status", rdat, 32'h0000001A);
      stream(10, -1);
      finish_block();
      check("blk3_done_count", 32'(done_cnt - d0), 32'd1);
      rd(5'd16, rdat); check("blk3_status", rdat, 32'h000A100B);
      rd(5'd17, rdat); check("blk3_counter", rdat, 32'd1);
      rd(5'd9, rdat);  check("blk3_ct9", rdat, 32'hC009);
      rd(5'd10, rdat); check("blk3_ct10", rdat, 32'd0);
      rd(5'd15, rdat); check("blk3_ct15", rdat, 32'd0);
      wr(5'd13, 32'h8000_0000);
      rd(5'd16, rdat); check("err_clear", rdat & 32'h7, 32'd0);

      // Block 4: command while running, then reset mid-block
      s0 = start_cnt; d0 = done_cnt;
      begin_block(0);
      wr(5'd13, 32'd1);
      rd(5'd16, rdat); check("cmd_err_status", rdat & 32'h17, 32'h14);
      check("blk4_start_count", 32'(start_cnt - s0), 32'd1);
      @(negedge clk);
      chunk_request = 1'b1; in_state_ready = 1'b1;
      out_state_valid = 1'b1; out_state_word = 32'hDEAD;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_idle_outputs("rst_in_run");
      rst = 1'b0; chunk_request = 1'b0; in_state_ready = 1'b0; out_state_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_no_blk_done", 32'(done_cnt - d0), 32'd0);
      rd(5'd16, rdat); check("rst_status", rdat, 32'd0);
      rd(5'd17, rdat); check("rst_counter", rdat, 32'd0);
      rd(5'd0, rdat);  check("rst_ct0", rdat, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
